// File: rtl/chan_select_pipe.sv
// Registered NCH-way channel select feeding a 2-entry valid/ready output buffer with a wrapping beat counter.
// Optional: define CHAN_SELECT_ERR_EN to add the sticky sel_err output for out-of-range selects.
module chan_select_pipe #(
   parameter int NCH = 3,
   parameter int W   = 3,
   parameter int SW  = (NCH > 2) ? $clog2(NCH - 1) : 1,
   parameter int CW  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCH*W-1:0]         in_data,
   input  logic                     in_force,
   input  logic [SW-1:0]            in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [W-1:0]             out_data,
   output logic [$clog2(NCH)-1:0]   out_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
`ifdef CHAN_SELECT_ERR_EN
   output logic                     sel_err,
`endif
   output logic [CW-1:0]            beat_cnt
);

   localparam int CHW = $clog2(NCH);

   function automatic logic sel_oor(input logic [SW-1:0] sel);
      return int'(sel) > (NCH - 2);
   endfunction

   // Saturating channel map: force wins, then sel+1, clamped to the last channel.
   function automatic logic [CHW-1:0] sel_chan(input logic force_bit, input logic [SW-1:0] sel);
      if (force_bit)
         return '0;
      if (!sel_oor(sel))
         return CHW'(int'(sel) + 1);
      return CHW'(NCH - 1);
   endfunction

   logic [CHW-1:0] sel_ch;
   logic [W-1:0]   sel_word;

   always_comb begin
      sel_ch   = sel_chan(in_force, in_sel);
      sel_word = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel_ch == CHW'(k))
            sel_word = in_data[k*W +: W];
      end
   end

   // Stage p0: two-entry output buffer (head drives the outputs, tail holds the second beat).
   logic [1:0]     count_p0;
   logic [W-1:0]   head_data_p0;
   logic [CHW-1:0] head_ch_p0;
   logic [W-1:0]   tail_data_p0;
   logic [CHW-1:0] tail_ch_p0;
   logic [CW-1:0]  beat_cnt_p0;
   logic           vld_p0;
   logic           push;
   logic           pop;

   assign vld_p0   = (count_p0 != 2'd0);
   assign in_ready = (count_p0 != 2'd2) && !rst;
   assign push     = in_valid && in_ready;
   assign pop      = vld_p0 && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_p0     <= 2'd0;
         head_data_p0 <= '0;
         head_ch_p0   <= '0;
         beat_cnt_p0  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_p0 == 2'd0) begin
                  head_data_p0 <= sel_word;
                  head_ch_p0   <= sel_ch;
               end
               count_p0 <= count_p0 + 2'd1;
            end
            2'b01: begin
               if (count_p0 == 2'd2) begin
                  head_data_p0 <= tail_data_p0;
                  head_ch_p0   <= tail_ch_p0;
               end
               count_p0 <= count_p0 - 2'd1;
            end
            2'b11: begin
               // Only reachable at count 1: the departing head is replaced in place.
               head_data_p0 <= sel_word;
               head_ch_p0   <= sel_ch;
            end
            default: ;
         endcase
         if (pop)
            beat_cnt_p0 <= beat_cnt_p0 + CW'(1);
      end
   end

   // Tail is only ever read after it has been written behind a valid head, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push && !pop && (count_p0 == 2'd1)) begin
         tail_data_p0 <= sel_word;
         tail_ch_p0   <= sel_ch;
      end
   end

`ifdef CHAN_SELECT_ERR_EN
   logic sel_err_p0;

   always_ff @(posedge clk) begin
      if (rst)
         sel_err_p0 <= 1'b0;
      else if (push && !in_force && sel_oor(in_sel))
         sel_err_p0 <= 1'b1;
   end

   assign sel_err = sel_err_p0;
`endif

   assign out_valid = vld_p0;
   assign out_data  = head_data_p0;
   assign out_ch    = head_ch_p0;
   assign beat_cnt  = beat_cnt_p0;

endmodule

// File: tb/tb_chan_select_pipe.sv
// Randomized bench for chan_select_pipe against a queue-based reference model (NCH=4, W=3, CW=4).
// Checks sel_err as well when CHAN_SELECT_ERR_EN is defined.
module tb_chan_select_pipe;

   localparam int NCH = 4;
   localparam int W   = 3;
   localparam int SW  = 2;
   localparam int CW  = 4;
   localparam int CHW = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NCH*W-1:0]   in_data;
   logic               in_force;
   logic [SW-1:0]      in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       out_data;
   logic [CHW-1:0]     out_ch;
   logic               out_valid;
   logic               out_ready;
   logic [CW-1:0]      beat_cnt;
`ifdef CHAN_SELECT_ERR_EN
   logic               sel_err;
`endif

   logic [W-1:0] chan_word [NCH];

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int k = 0; k < NCH; k++)
         in_data[k*W +: W] = chan_word[k];
   end

   chan_select_pipe #(.NCH(NCH), .W(W), .SW(SW), .CW(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_force  (in_force),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef CHAN_SELECT_ERR_EN
      .sel_err   (sel_err),
`endif
      .beat_cnt  (beat_cnt)
   );

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic [W-1:0]   data;
   } beat_t;

   beat_t q[$];
   int    beats_m = 0;
   bit    err_m   = 1'b0;
   int    checks  = 0;
   int    errors  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_chan(input bit f, input int s);
      if (f) return 0;
      if (s <= NCH - 2) return s + 1;
      return NCH - 1;
   endfunction

   task automatic model_edge();
      bit    acc;
      bit    dlv;
      beat_t b;
      if (rst) begin
         q.delete();
         beats_m = 0;
         err_m   = 1'b0;
         return;
      end
      acc = in_valid && (q.size() != 2);
      dlv = out_ready && (q.size() != 0);
      b   = '0;
      if (acc) begin
         b.ch   = CHW'(ref_chan(in_force, int'(in_sel)));
         b.data = chan_word[b.ch];
      end
      if (dlv) begin
         void'(q.pop_front());
         beats_m = (beats_m + 1) % (1 << CW);
      end
      if (acc) begin
         q.push_back(b);
         if (!in_force && (int'(in_sel) > NCH - 2))
            err_m = 1'b1;
      end
   endtask

   task automatic compare_all();
      chk("in_ready", in_ready, (!rst && (q.size() != 2)));
      chk("out_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0].data);
         chk("out_ch", out_ch, q[0].ch);
      end
      chk("beat_cnt", beat_cnt, beats_m);
`ifdef CHAN_SELECT_ERR_EN
      chk("sel_err", sel_err, err_m);
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit v, input bit f, input int s, input bit r);
      in_valid  = v;
      in_force  = f;
      in_sel    = SW'(s);
      out_ready = r;
   endtask

   task automatic rand_words();
      for (int k = 0; k < NCH; k++)
         chan_word[k] = W'($urandom);
   endtask

   int          sel_f  [3] = '{1, 0, 0};
   int          sel_s  [3] = '{0, 0, 1};
   logic [W-1:0] sel_d [3] = '{3'b110, 3'b011, 3'b101};
   logic [CHW-1:0] sel_c [3] = '{2'd0, 2'd1, 2'd2};

   initial begin
      chan_word[0] = 3'b110;
      chan_word[1] = 3'b011;
      chan_word[2] = 3'b101;
      chan_word[3] = 3'b010;
      rst = 1'b1;
      drive(0, 0, 0, 1);
      cycle();
      cycle();
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      rst = 1'b0;
      #1 chk("ready_after_rst", in_ready, 1);

      // Selection table
      for (int i = 0; i < 3; i++) begin
         drive(1, sel_f[i] != 0, sel_s[i], 1);
         cycle();
         drive(0, 0, 0, 1);
         chk("sel_data", out_data, sel_d[i]);
         chk("sel_ch", out_ch, sel_c[i]);
         cycle();
      end

      // Out-of-range select saturates to the last channel
      drive(1, 0, 3, 1);
      cycle();
      drive(0, 0, 0, 1);
      chk("oor_ch", out_ch, 3);
      chk("oor_data", out_data, 3'b010);
      cycle();
      drive(1, 0, 1, 1);
      cycle();
      cycle();
      drive(0, 0, 0, 1);
      cycle();
`ifdef CHAN_SELECT_ERR_EN
      chk("sel_err_sticky", sel_err, 1);
`endif
      rst = 1'b1;
      cycle();
      rst = 1'b0;
`ifdef CHAN_SELECT_ERR_EN
      chk("sel_err_cleared", sel_err, 0);
`endif

      // Backpressure: A, B fill the buffer, a third beat is refused
      drive(1, 0, 0, 0);
      cycle();
      drive(1, 0, 1, 0);
      cycle();
      chk("full_ready", in_ready, 0);
      drive(1, 1, 0, 0);
      cycle();
      cycle();
      chk("hold_head", out_data, 3'b011);
      drive(0, 0, 0, 1);
      cycle();
      chk("second_head", out_data, 3'b101);
      cycle();
      chk("bp_beats", beat_cnt, 2);
      chk("bp_empty", out_valid, 0);

      // Continuous push/pop at count 1
      for (int i = 0; i < 100; i++) begin
         rand_words();
         drive(1, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1);
         cycle();
         if (i > 0) chk("stream_ready", in_ready, 1);
      end
      drive(0, 0, 0, 1);
      cycle();
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) rand_words();
         drive($urandom_range(0, 2) != 0, ($urandom_range(0, 3) == 0),
               $urandom_range(0, 3), $urandom_range(0, 2) != 0);
         cycle();
      end

      // Counter wrap: 17 deliveries from reset with CW=4
      rst = 1'b1;
      drive(0, 0, 0, 1);
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rand_words();
         drive(1, 0, $urandom_range(0, 3), 1);
         cycle();
      end
      drive(0, 0, 0, 1);
      cycle();
      cycle();
      chk("wrap", beat_cnt, 1);

      // Reset mid-operation with a full buffer
      drive(1, 0, 0, 0);
      cycle();
      cycle();
      chk("pre_rst_full", in_ready, 0);
      rst = 1'b1;
      drive(1, 0, 0, 0);
      #1 chk("rst_ready_low", in_ready, 0);
      cycle();
      chk("rst_valid", out_valid, 0);
      chk("rst_beats", beat_cnt, 0);
      rst = 1'b0;
      drive(0, 0, 0, 1);
      #1 chk("rel_ready", in_ready, 1);
      cycle();
      chk("no_stale", out_valid, 0);
      cycle();
      chk("no_stale_cnt", beat_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
